grad_cells_valve_seq: RTL and testbench

- Electronic pneumatic sequencer directly upstream of the grad_cells device.
- Drives the four MUX control lines (cpb1_1, cpb1_2, cpb2_1, cpb2_2) so gradient-generator output is routed to one LONG_CELL_TRAP branch pair for a commanded dwell.
- Uses break-before-make sequencing: the outlet valve opens before the inlet valve and closes after it.
- Accepts commands over a valid/ready handshake and reports completion.

---
 rtl/grad_cells_pkg.sv | 24 ++
 rtl/seq_timer.sv | 27 ++
 rtl/grad_cells_valve_seq.sv | 166 ++++++++++++++++
 tb/tb_grad_cells_valve_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_cells_pkg.sv
// Shared types and constants for the grad_cells valve sequencer.
package grad_cells_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_A,
    DWELL,
    SETTLE_B,
    DONE
  } seq_state_t;

  localparam int CTRL_IN_A  = 0;
  localparam int CTRL_IN_B  = 1;
  localparam int CTRL_OUT_A = 2;
  localparam int CTRL_OUT_B = 3;

  localparam logic BR_A = 1'b0;
  localparam logic BR_B = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; zero flags the final cycle of a timed phase.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (dec && (value_reg != '0)) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign zero = (value_reg == '0);

endmodule

// File: rtl/grad_cells_valve_seq.sv
// Break-before-make pneumatic sequencer driving the four grad_cells MUX lines.
module grad_cells_valve_seq
  import grad_cells_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_W       = 16,
  parameter int PRESS_CLOSES  = 1,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_branch,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [3:0]         ctrl,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               active_branch,
  output logic [CNT_W-1:0]   done_count
);

  localparam int             TW          = max_int($clog2(SETTLE_CYCLES + 1), DWELL_W);
  localparam logic [TW-1:0]  SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic           CLOSED      = (PRESS_CLOSES != 0);

  seq_state_t         state_reg, state_next;
  logic               branch_reg, branch_next;
  logic [DWELL_W-1:0] dwell_m1_reg, dwell_m1_next;
  logic               abort_seen_reg, abort_seen_next;
  logic               aborted_reg, aborted_next;
  logic [3:0]         ctrl_reg, ctrl_next, open_next;
  logic               cmd_ready_reg, busy_reg, done_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               accept;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]      tmr_load_value;

  // Timer is loaded with (count - 1) so its zero flag marks the last cycle of a phase.
  seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  assign accept = (state_reg == IDLE) && cmd_valid;

  always_comb begin
    state_next      = state_reg;
    branch_next     = branch_reg;
    dwell_m1_next   = dwell_m1_reg;
    abort_seen_next = abort_seen_reg;
    tmr_load        = 1'b0;
    tmr_load_value  = SETTLE_LOAD;
    tmr_dec         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next      = SETTLE_A;
          branch_next     = cmd_branch;
          dwell_m1_next   = (cmd_dwell == '0) ? '0 : cmd_dwell - 1'b1;
          abort_seen_next = 1'b0;
          tmr_load        = 1'b1;
        end
      end
      SETTLE_A: begin
        if (abort) begin
          state_next      = DONE;
          abort_seen_next = 1'b1;
        end else if (tmr_zero) begin
          state_next     = DWELL;
          tmr_load       = 1'b1;
          tmr_load_value = TW'(dwell_m1_reg);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DWELL: begin
        if (abort || tmr_zero) begin
          state_next = SETTLE_B;
          tmr_load   = 1'b1;
          if (abort) abort_seen_next = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE_B: begin
        if (tmr_zero) state_next = DONE;
        else          tmr_dec    = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    open_next = 4'b0000;
    if (state_next == SETTLE_A || state_next == SETTLE_B || state_next == DWELL) begin
      open_next[(branch_next == BR_A) ? CTRL_OUT_A : CTRL_OUT_B] = 1'b1;
    end
    if (state_next == DWELL) begin
      open_next[(branch_next == BR_A) ? CTRL_IN_A : CTRL_IN_B] = 1'b1;
    end
    ctrl_next = CLOSED ? ~open_next : open_next;

    aborted_next = aborted_reg;
    if (accept) aborted_next = 1'b0;
    else if (state_next == DONE && abort_seen_next) aborted_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      branch_reg     <= BR_A;
      dwell_m1_reg   <= '0;
      abort_seen_reg <= 1'b0;
      aborted_reg    <= 1'b0;
      ctrl_reg       <= {4{CLOSED}};
      cmd_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      branch_reg     <= branch_next;
      dwell_m1_reg   <= dwell_m1_next;
      abort_seen_reg <= abort_seen_next;
      aborted_reg    <= aborted_next;
      ctrl_reg       <= ctrl_next;
      cmd_ready_reg  <= (state_next == IDLE);
      busy_reg       <= (state_next == SETTLE_A) || (state_next == DWELL) || (state_next == SETTLE_B);
      done_reg       <= (state_next == DONE);
      if (state_next == DONE) count_reg <= count_reg + 1'b1;
    end
  end

  assign ctrl          = ctrl_reg;
  assign cmd_ready     = cmd_ready_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign aborted       = aborted_reg;
  assign active_branch = branch_reg;
  assign done_count    = count_reg;

  // Safety invariants on the physical valve state.
  logic [3:0] open_v;
  assign open_v = CLOSED ? ~ctrl_reg : ctrl_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(open_v[CTRL_IN_A] && open_v[CTRL_IN_B]));
      assert (!(open_v[CTRL_IN_A] && !open_v[CTRL_OUT_A]));
      assert (!(open_v[CTRL_IN_B] && !open_v[CTRL_OUT_B]));
      assert (!((open_v[CTRL_IN_A] || open_v[CTRL_OUT_A]) &&
                (open_v[CTRL_IN_B] || open_v[CTRL_OUT_B])));
    end
  end

endmodule

// File: tb/tb_grad_cells_valve_seq.sv
// Randomized self-checking bench for grad_cells_valve_seq against a phase-list model.
module tb_grad_cells_valve_seq;

  localparam int S  = 4;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, cmd_branch, abort;
  logic          busy, done, aborted, active_branch;
  logic [DW-1:0] cmd_dwell;
  logic [3:0]    ctrl;
  logic [CW-1:0] done_count;

  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_count = '0;

  always #5 clk = ~clk;

  grad_cells_valve_seq #(
    .SETTLE_CYCLES (S),
    .DWELL_W       (DW),
    .PRESS_CLOSES  (1),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_branch    (cmd_branch),
    .cmd_dwell     (cmd_dwell),
    .abort         (abort),
    .ctrl          (ctrl),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .active_branch (active_branch),
    .done_count    (done_count)
  );

  // Expected ctrl for a phase: 0 all closed, 1 outlet only, 2 inlet and outlet.
  function automatic logic [3:0] exp_ctrl(input int phase, input bit br);
    logic [3:0] e;
    e = 4'b1111;
    if (phase >= 1) e[br ? 3 : 2] = 1'b0;
    if (phase == 2) e[br ? 1 : 0] = 1'b0;
    return e;
  endfunction

  // One command from IDLE to the cycle after DONE; a = cycle index (1-based after accept) carrying abort.
  task automatic run_cmd(input bit br, input int dw, input int a, input bit abort_at_accept, input string tag);
    int d, n1, n2, n3, len;
    bit ab;
    int ph[$];
    logic [CW-1:0] prev_count;
    logic [3:0] e;
    d = (dw == 0) ? 1 : dw;
    if (a >= 1 && a <= S) begin
      n1 = a; n2 = 0; n3 = 0; ab = 1;
    end else if (a > S && a <= S + d) begin
      n1 = S; n2 = a - S; n3 = S; ab = 1;
    end else begin
      n1 = S; n2 = d; n3 = S; ab = 0;
    end
    repeat (n1) ph.push_back(1);
    repeat (n2) ph.push_back(2);
    repeat (n3) ph.push_back(1);
    ph.push_back(0);
    len = ph.size();
    prev_count = exp_count;
    exp_count = exp_count + 1'b1;

    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_branch = br; cmd_dwell = DW'(dw); abort = abort_at_accept;
    @(posedge clk);
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_branch = 1'($urandom); cmd_dwell = DW'($urandom);
      abort = (i == a);
      e = exp_ctrl(ph[i-1], br);
      vectors++;
      if (ctrl !== e) begin
        miscompares++;
        $display("FAIL %s ctrl cyc%0d: got %b want %b", tag, i, ctrl, e);
      end
      vectors++;
      if (done !== (i == len) || busy !== (i < len) || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s flags cyc%0d: got done=%b busy=%b ready=%b want done=%b busy=%b ready=0",
                 tag, i, done, busy, cmd_ready, (i == len), (i < len));
      end
      vectors++;
      if (aborted !== ((i == len) ? ab : 1'b0) || active_branch !== br) begin
        miscompares++;
        $display("FAIL %s abrt/branch cyc%0d: got %b/%b want %b/%b",
                 tag, i, aborted, active_branch, (i == len) ? ab : 1'b0, br);
      end
      vectors++;
      if (done_count !== ((i == len) ? exp_count : prev_count)) begin
        miscompares++;
        $display("FAIL %s done_count cyc%0d: got %0d want %0d", tag, i, done_count,
                 (i == len) ? exp_count : prev_count);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || ctrl !== 4'b1111 ||
        done_count !== exp_count || aborted !== ab) begin
      miscompares++;
      $display("FAIL %s after_done: got ready=%b done=%b busy=%b ctrl=%b cnt=%0d abrt=%b want 1 0 0 1111 %0d %b",
               tag, cmd_ready, done, busy, ctrl, done_count, aborted, exp_count, ab);
    end
    $display("cmd %s: branch=%0d dwell=%0d abort_cyc=%0d cycles=%0d count=%0d", tag, br, dw, a, len, done_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; abort = 1'b0; cmd_branch = 1'b1; cmd_dwell = 16'd5;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (ctrl !== 4'b1111 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || active_branch !== 1'b0 || done_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ctrl=%b ready=%b busy=%b done=%b abrt=%b br=%b cnt=%0d want 1111 1 0 0 0 0 0",
               ctrl, cmd_ready, busy, done, aborted, active_branch, done_count);
    end
    rst = 1'b0;
    exp_count = '0;
    $display("reset: ctrl=%b ready=%b cnt=%0d", ctrl, cmd_ready, done_count);
  endtask

  task automatic test_branch_a();     run_cmd(1'b0, 3, 0, 1'b0, "branch_a_dwell3"); endtask
  task automatic test_branch_b_dwell0(); run_cmd(1'b1, 0, 0, 1'b0, "branch_b_dwell0"); endtask
  task automatic test_abort_dwell();  run_cmd(1'b0, 10, S + 2, 1'b0, "abort_dwell"); endtask

  task automatic test_abort_settle();
    run_cmd(1'b1, 5, 2, 1'b0, "abort_settle");
    run_cmd(1'b1, 2, 0, 1'b0, "after_abort_normal");
  endtask

  task automatic test_abort_idle();   run_cmd(1'b0, 4, 0, 1'b1, "abort_in_idle"); endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      bit br;
      int dw, d, sel, a;
      br  = 1'($urandom);
      dw  = $urandom_range(0, 12);
      d   = (dw == 0) ? 1 : dw;
      sel = $urandom_range(0, 3);
      case (sel)
        1:       a = $urandom_range(1, S);
        2:       a = $urandom_range(S + 1, S + d);
        3:       a = $urandom_range(S + d + 1, 2 * S + d);
        default: a = 0;
      endcase
      run_cmd(br, dw, a, 1'($urandom), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_rst_mid();
    cmd_valid = 1'b1; cmd_branch = 1'b1; cmd_dwell = 16'd10; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (S + 1) @(negedge clk);
    vectors++;
    if (ctrl !== 4'b0101) begin
      miscompares++;
      $display("FAIL rst_mid pre_ctrl: got %b want 0101", ctrl);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    vectors++;
    if (ctrl !== 4'b1111 || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid post: got ctrl=%b done=%b ready=%b busy=%b cnt=%0d want 1111 0 1 0 0",
               ctrl, done, cmd_ready, busy, done_count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || ctrl !== 4'b1111) begin
        miscompares++;
        $display("FAIL rst_mid quiet%0d: got done=%b ctrl=%b want 0 1111", i, done, ctrl);
      end
    end
    $display("rst_mid: ctrl=%b ready=%b cnt=%0d", ctrl, cmd_ready, done_count);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_valid = 1'b1; abort = 1'b0;
    for (int j = 0; j < 256; j++) begin
      int dw, len;
      dw  = $urandom_range(0, 3);
      len = 2 * S + ((dw == 0) ? 1 : dw) + 1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b%0d ready_idle: got %b want 1", j, cmd_ready);
      end
      cmd_branch = 1'($urandom); cmd_dwell = DW'(dw);
      exp_count = exp_count + 1'b1;
      for (int i = 1; i <= len; i++) begin
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0 || done !== (i == len)) begin
          miscompares++;
          $display("FAIL b2b%0d cyc%0d: got ready=%b done=%b want 0 %b", j, i, cmd_ready, done, (i == len));
        end
      end
      vectors++;
      if (done_count !== exp_count) begin
        miscompares++;
        $display("FAIL b2b%0d count: got %0d want %0d", j, done_count, exp_count);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    vectors++;
    if (done_count !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b wrap: got %0d want 0", done_count);
    end
    $display("back_to_back: 256 commands, done_count=%0d", done_count);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_branch = 1'b0; cmd_dwell = '0; abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_branch_a();
    test_branch_b_dwell0();
    test_abort_dwell();
    test_abort_settle();
    test_abort_idle();
    test_random();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
